// File: rtl/intersection_controller.sv
// ============================================================================
// intersection_controller : two-road signal sequencer with all-red clearance,
// latched vehicle/pedestrian demand and a shared pedestrian WALK phase.
// Revision: 1.0
// ============================================================================
`default_nettype none

module intersection_controller #(
  parameter int GREEN_CYCLES  = 64,
  parameter int YELLOW_CYCLES = 16,
  parameter int ALLRED_CYCLES = 4,
  parameter int WALK_CYCLES   = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic car_ew,
  input  logic ped_req,
  output logic ns_r,
  output logic ns_y,
  output logic ns_g,
  output logic ew_r,
  output logic ew_y,
  output logic ew_g,
  output logic walk,
  output logic ped_pending
);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_A  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_B  = 3'd5,
    WALK      = 3'd6
  } state_t;

  localparam logic [7:0] GREEN_LAST  = 8'(GREEN_CYCLES - 1);
  localparam logic [7:0] YELLOW_LAST = 8'(YELLOW_CYCLES - 1);
  localparam logic [7:0] ALLRED_LAST = 8'(ALLRED_CYCLES - 1);
  localparam logic [7:0] WALK_LAST   = 8'(WALK_CYCLES - 1);

  state_t     state;
  state_t     state_next;
  logic [7:0] count;
  logic [7:0] dwell_last;
  logic       dwell_done;
  logic       ew_demand;
  logic       ew_demand_next;
  logic       ped_pending_next;

  always_comb begin
    dwell_last = ALLRED_LAST;
    case (state)
      NS_GREEN, EW_GREEN:   dwell_last = GREEN_LAST;
      NS_YELLOW, EW_YELLOW: dwell_last = YELLOW_LAST;
      WALK:                 dwell_last = WALK_LAST;
      default:              dwell_last = ALLRED_LAST;
    endcase
  end

  assign dwell_done = (count == dwell_last);

  always_comb begin
    state_next = state;
    if (dwell_done) begin
      case (state)
        NS_GREEN:  state_next = (ew_demand | car_ew | ped_pending | ped_req) ? NS_YELLOW : NS_GREEN;
        NS_YELLOW: state_next = ALLRED_A;
        ALLRED_A:  state_next = EW_GREEN;
        EW_GREEN:  state_next = EW_YELLOW;
        EW_YELLOW: state_next = ALLRED_B;
        ALLRED_B:  state_next = ped_pending ? WALK : NS_GREEN;
        WALK:      state_next = NS_GREEN;
        default:   state_next = ALLRED_B;
      endcase
    end
  end

  // Clearing on phase entry takes priority over a request seen in the same cycle.
  always_comb begin
    ew_demand_next   = ew_demand | (car_ew & (state != EW_GREEN));
    ped_pending_next = ped_pending | (ped_req & (state != WALK));
    if (dwell_done && state == ALLRED_A) begin
      ew_demand_next = 1'b0;
    end
    if (dwell_done && state == ALLRED_B && ped_pending) begin
      ped_pending_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ALLRED_B;
      count       <= 8'd0;
      ew_demand   <= 1'b0;
      ped_pending <= 1'b0;
    end else begin
      state       <= state_next;
      count       <= dwell_done ? 8'd0 : count + 8'd1;
      ew_demand   <= ew_demand_next;
      ped_pending <= ped_pending_next;
    end
  end

  always_comb begin
    ns_r = 1'b0;
    ns_y = 1'b0;
    ns_g = 1'b0;
    ew_r = 1'b0;
    ew_y = 1'b0;
    ew_g = 1'b0;
    walk = 1'b0;
    case (state)
      NS_GREEN:  begin ns_g = 1'b1; ew_r = 1'b1; end
      NS_YELLOW: begin ns_y = 1'b1; ew_r = 1'b1; end
      EW_GREEN:  begin ew_g = 1'b1; ns_r = 1'b1; end
      EW_YELLOW: begin ew_y = 1'b1; ns_r = 1'b1; end
      WALK:      begin ns_r = 1'b1; ew_r = 1'b1; walk = 1'b1; end
      default:   begin ns_r = 1'b1; ew_r = 1'b1; end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_intersection_controller.sv
// ============================================================================
// tb_intersection_controller : directed + random checks of two controller
// instances (default timing and all-dwells-one) against a phase-table model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_intersection_controller;

  localparam int G = 64;
  localparam int Y = 16;
  localparam int A = 4;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic car_ew = 1'b0;
  logic ped_req = 1'b0;
  logic ped1 = 1'b0;

  logic a_ns_r, a_ns_y, a_ns_g, a_ew_r, a_ew_y, a_ew_g, a_walk, a_pp;
  logic b_ns_r, b_ns_y, b_ns_g, b_ew_r, b_ew_y, b_ew_g, b_walk, b_pp;

  int vectors = 0;
  int miscompares = 0;
  int walk_seen = 0;

  // Model: phase 0..6 = NS green, NS yellow, all-red A, EW green, EW yellow, all-red B, walk
  int ph[2];
  int left[2];
  bit ewd[2];
  bit pp[2];

  always #5 clk = ~clk;

  intersection_controller #(
    .GREEN_CYCLES(G), .YELLOW_CYCLES(Y), .ALLRED_CYCLES(A), .WALK_CYCLES(W)
  ) dut_a (
    .clk(clk), .reset(reset), .car_ew(car_ew), .ped_req(ped_req),
    .ns_r(a_ns_r), .ns_y(a_ns_y), .ns_g(a_ns_g),
    .ew_r(a_ew_r), .ew_y(a_ew_y), .ew_g(a_ew_g),
    .walk(a_walk), .ped_pending(a_pp)
  );

  intersection_controller #(
    .GREEN_CYCLES(1), .YELLOW_CYCLES(1), .ALLRED_CYCLES(1), .WALK_CYCLES(1)
  ) dut_b (
    .clk(clk), .reset(reset), .car_ew(1'b1), .ped_req(ped1),
    .ns_r(b_ns_r), .ns_y(b_ns_y), .ns_g(b_ns_g),
    .ew_r(b_ew_r), .ew_y(b_ew_y), .ew_g(b_ew_g),
    .walk(b_walk), .ped_pending(b_pp)
  );

  function automatic int dwell(int k, int p);
    if (k == 1) return 1;
    case (p)
      0, 3:    return G;
      1, 4:    return Y;
      6:       return W;
      default: return A;
    endcase
  endfunction

  // {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk}
  function automatic logic [6:0] lamps(int p);
    case (p)
      0:       return 7'b0011000;
      1:       return 7'b0101000;
      3:       return 7'b1000010;
      4:       return 7'b1000100;
      6:       return 7'b1001001;
      default: return 7'b1001000;
    endcase
  endfunction

  function automatic logic lamps_ok(logic [6:0] l);
    logic one_ns, one_ew;
    one_ns = (l[6] + l[5] + l[4]) == 2'd1;
    one_ew = (l[3] + l[2] + l[1]) == 2'd1;
    return one_ns && one_ew && (!l[0] || (l[6] && l[3]));
  endfunction

  task automatic step(int k, logic rst, logic car, logic ped);
    bit last;
    int nph;
    if (rst) begin
      ph[k] = 5; left[k] = dwell(k, 5); ewd[k] = 0; pp[k] = 0;
      return;
    end
    last = (left[k] == 1);
    nph = ph[k];
    if (last) begin
      case (ph[k])
        0: nph = (ewd[k] || car || pp[k] || ped) ? 1 : 0;
        5: nph = pp[k] ? 6 : 0;
        6: nph = 0;
        default: nph = ph[k] + 1;
      endcase
    end
    if (last && ph[k] == 2) ewd[k] = 0;
    else ewd[k] = ewd[k] | (car && ph[k] != 3);
    if (last && ph[k] == 5 && pp[k]) pp[k] = 0;
    else pp[k] = pp[k] | (ped && ph[k] != 6);
    left[k] = last ? dwell(k, nph) : left[k] - 1;
    ph[k] = nph;
  endtask

  task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      step(0, reset, car_ew, ped_req);
      step(1, reset, 1'b1, ped1);
      #1;
      check("dut_a_outputs", {a_ns_r, a_ns_y, a_ns_g, a_ew_r, a_ew_y, a_ew_g, a_walk, a_pp},
            {lamps(ph[0]), pp[0]});
      check("dut_b_outputs", {b_ns_r, b_ns_y, b_ns_g, b_ew_r, b_ew_y, b_ew_g, b_walk, b_pp},
            {lamps(ph[1]), pp[1]});
      check("dut_a_invariant", {7'd0, lamps_ok({a_ns_r, a_ns_y, a_ns_g, a_ew_r, a_ew_y, a_ew_g, a_walk})}, 8'd1);
      check("dut_b_invariant", {7'd0, lamps_ok({b_ns_r, b_ns_y, b_ns_g, b_ew_r, b_ew_y, b_ew_g, b_walk})}, 8'd1);
      if (a_walk) walk_seen++;
      ped1 = ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic run_until(string tag, int p, int l, int budget);
    bit found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      tick(1);
      found = (ph[0] == p && left[0] == l);
    end
    check(tag, {7'd0, found}, 8'd1);
  endtask

  initial begin
    // Reset and release: 4 all-red cycles, then rest in NS green
    reset = 1'b1;
    tick(3);
    check("reset_allred", {6'd0, a_ns_r, a_ew_r}, 8'b11);
    check("reset_pp", {7'd0, a_pp}, 8'd0);
    reset = 1'b0;
    tick(3);
    check("release_still_red", {7'd0, a_ns_g}, 8'd0);
    tick(1);
    check("first_ns_green", {7'd0, a_ns_g}, 8'd1);
    tick(300);
    check("rest_in_green", {6'd0, a_ns_g, a_ns_y}, 8'b10);

    // Single-cycle vehicle pulse
    walk_seen = 0;
    car_ew = 1'b1;
    tick(1);
    car_ew = 1'b0;
    tick(200);
    check("car_cycle_back_green", {7'd0, a_ns_g}, 8'd1);
    check("car_cycle_no_walk", walk_seen[7:0], 8'd0);

    // Pedestrian pulse at NS green count 10
    run_until("reach_ns_count10", 0, G - 10, 400);
    ped_req = 1'b1;
    tick(1);
    ped_req = 1'b0;
    check("ped_pending_rise", {7'd0, a_pp}, 8'd1);
    walk_seen = 0;
    tick(210);
    check("walk_duration", walk_seen[7:0], 8'(W));
    check("walk_cleared_pp", {7'd0, a_pp}, 8'd0);

    // Request held across the WALK grant and throughout WALK
    ped_req = 1'b1;
    tick(1);
    ped_req = 1'b0;
    run_until("reach_allred_b_last", 5, 1, 400);
    ped_req = 1'b1;
    run_until("reach_green_after_walk", 0, G, 100);
    ped_req = 1'b0;
    tick(1);
    check("held_ped_ignored", {7'd0, a_pp}, 8'd0);
    tick(100);
    check("no_second_walk", {6'd0, a_ns_g, a_walk}, 8'b10);

    // Reset in the middle of EW green with a pending pedestrian
    car_ew = 1'b1;
    ped_req = 1'b1;
    tick(1);
    car_ew = 1'b0;
    ped_req = 1'b0;
    run_until("reach_ew_count30", 3, G - 30, 400);
    check("pp_before_reset", {7'd0, a_pp}, 8'd1);
    reset = 1'b1;
    tick(1);
    check("midreset_allred", {5'd0, a_ns_r, a_ew_r, a_walk}, 8'b110);
    check("midreset_pp", {7'd0, a_pp}, 8'd0);
    reset = 1'b0;
    tick(4);
    check("midreset_green", {7'd0, a_ns_g}, 8'd1);

    // Randomised traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      car_ew  = ($urandom_range(0, 7) == 0);
      ped_req = ($urandom_range(0, 15) == 0);
      reset   = ($urandom_range(0, 499) == 0);
      tick(1);
    end
    reset = 1'b0;
    car_ew = 1'b0;
    ped_req = 1'b0;
    tick(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/intersection_controller.md
# intersection_controller

Sequencing controller for a two-road signalised intersection. It drives the north-south and east-west red/yellow/green lamp sets plus a shared pedestrian WALK lamp from one dwell-timed state machine. It guarantees an all-red clearance interval between conflicting greens and serves latched vehicle and pedestrian demand. It sits above the single-approach traffic-light datapath and replaces free-running per-approach timing with coordinated phases.

## Interface

- GREEN_CYCLES, 64, dwell of each green phase in clk cycles (legal range 1..256)
- YELLOW_CYCLES, 16, dwell of each yellow phase (1..256)
- ALLRED_CYCLES, 4, dwell of each all-red clearance phase (1..256)
- WALK_CYCLES, 32, dwell of the pedestrian WALK phase (1..256)

- clk  input  1  single clock; all state changes on posedge clk
- reset  input  1  synchronous, active-high reset
- car_ew  input  1  east-west vehicle sensor, level, sampled every cycle
- ped_req  input  1  pedestrian button, sampled every cycle
- ns_r, ns_y, ns_g  output  1 each  north-south lamps, exactly one high
- ew_r, ew_y, ew_g  output  1 each  east-west lamps, exactly one high
- walk  output  1  pedestrian WALK lamp
- ped_pending  output  1  registered pedestrian request awaiting service

## Operation

- States: NS_GREEN, NS_YELLOW, ALLRED_A, EW_GREEN, EW_YELLOW, ALLRED_B, WALK.
- Dwell counter: 8 bits, cleared to 0 on every state transition and incremented otherwise. A state exits in the cycle where count == DWELL-1, so each state visit lasts exactly DWELL cycles.
- Transitions at dwell end:
  - NS_GREEN -> NS_YELLOW if (ew_demand | car_ew | ped_pending | ped_req). Otherwise it stays in NS_GREEN and the count restarts at 0 (rest-in-green).
  - NS_YELLOW -> ALLRED_A -> EW_GREEN -> EW_YELLOW -> ALLRED_B.
  - ALLRED_B -> WALK if ped_pending, else NS_GREEN.
  - WALK -> NS_GREEN.
- ew_demand (internal register):
  - Set by car_ew in any state except EW_GREEN.
  - Cleared on the transition into EW_GREEN. The clear wins over a same-cycle set.
- ped_pending:
  - Set by ped_req in any state except WALK; ped_req during WALK is ignored.
  - Cleared on the transition ALLRED_B -> WALK. The clear wins over a same-cycle set.
- Lamp decode is a Moore decode of the state register:
  - NS_GREEN: ns_g, ew_r.
  - NS_YELLOW: ns_y, ew_r.
  - EW_GREEN: ew_g, ns_r.
  - EW_YELLOW: ew_y, ns_r.
  - ALLRED_A, ALLRED_B: ns_r, ew_r.
  - WALK: ns_r, ew_r, walk.
- Invariants: ns_g/ns_y and ew_g/ew_y are never high together; walk implies ns_r & ew_r.

## Timing

- Reset: state = ALLRED_B, count = 0, ew_demand = 0, ped_pending = 0.
- Outputs during and immediately after reset: ns_r = ew_r = 1, all other lamps 0, walk = 0, ped_pending = 0.
- First NS_GREEN begins ALLRED_CYCLES cycles after reset deasserts. No WALK occurs, because ped_pending is 0 unless ped_req is asserted after reset.
- Reset asserted mid-phase takes effect at the next posedge regardless of state or count. All latched demand is discarded.
- Lamp outputs change in the same cycle as the state register: zero-cycle decode latency from the state flop, one cycle from the triggering input.
- Demand registers update one cycle after input sampling. ped_pending rises the cycle after ped_req.
- Full cycle with defaults and both demands present: 64+16+4+64+16+4+32 = 200 cycles from NS_GREEN entry back to NS_GREEN entry.
- Full cycle without pedestrian demand: 168 cycles.
- DWELL = 1 is legal: the state lasts one cycle and count never leaves 0.

## Test plan

- Reset release, no inputs:
  - ns_r & ew_r for 4 cycles, then ns_g.
  - ns_g stays high indefinitely with no yellow (rest-in-green) over at least 300 cycles.
- car_ew pulsed for 1 cycle during NS_GREEN:
  - Yellow at the next dwell end, then 4 all-red cycles, 64 ew_g cycles, 16 ew_y cycles, 4 all-red cycles, then ns_g.
  - walk stays 0 throughout.
- ped_req pulsed once at NS_GREEN count 10:
  - ped_pending high from the next cycle.
  - Full 200-cycle sequence with walk high for exactly 32 cycles, ns_r & ew_r held.
  - ped_pending low from WALK entry.
- ped_req held during WALK and in the ALLRED_B -> WALK transition cycle:
  - ped_pending stays 0 after WALK; the following ALLRED_B goes to NS_GREEN.
- Reset asserted at EW_GREEN count 30 with ped_pending = 1:
  - Next cycle all-red, ped_pending = 0, walk = 0.
  - ns_g after 4 cycles.
- Run with GREEN_CYCLES=1, YELLOW_CYCLES=1, ALLRED_CYCLES=1, WALK_CYCLES=1 and car_ew held high:
  - Each phase lasts 1 cycle.
  - Lamp invariants hold on every cycle, checked by assertion.
